// File: rtl/step_pulse_gen.sv
// step_pulse_gen: debounced push-button / free-running step clock generator for a CPU.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES = 4,
  parameter int AUTO_PERIOD = 50000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        button,
  input  logic        auto_en,
  output logic        step_clk,
  output logic        btn_level,
  output logic [15:0] step_count
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] PW_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [31:0] AP_LAST = 32'(AUTO_PERIOD - 1);
  state_t state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic sync1_q, sync2_q;
  logic [31:0] div_q, div_d;
  logic [7:0] pulse_q, pulse_d, guard_q, guard_d;
  logic step_clk_q, step_clk_d, btn_level_q, btn_level_d;
  logic [15:0] step_count_q, step_count_d;
  logic man_req, div_wrap, req;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    man_req = 1'b0;
    case (state_q)
      IDLE: if (sync2_q) begin
        state_d = PRESS_WAIT;
        cnt_d = '0;
      end
      PRESS_WAIT: if (!sync2_q) state_d = IDLE;
        else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          man_req = 1'b1;
        end else cnt_d = cnt_q + 24'd1;
      HELD: if (!sync2_q) begin
        state_d = RELEASE_WAIT;
        cnt_d = '0;
      end
      RELEASE_WAIT: if (sync2_q) state_d = HELD;
        else if (cnt_q == DB_LAST) state_d = IDLE;
        else cnt_d = cnt_q + 24'd1;
      default: state_d = IDLE;
    endcase
    btn_level_d = state_d == HELD || state_d == RELEASE_WAIT;
  end
  // Requests landing during a pulse or its guard window are simply lost.
  always_comb begin
    div_wrap = div_q == AP_LAST;
    div_d = auto_en ? (div_wrap ? 32'd0 : div_q + 32'd1) : 32'd0;
    req = auto_en ? div_wrap : man_req;
    step_clk_d = step_clk_q ? pulse_q != PW_LAST : req && guard_q == 8'd0;
    pulse_d = step_clk_q && pulse_q != PW_LAST ? pulse_q + 8'd1 : 8'd0;
    guard_d = step_clk_q && pulse_q == PW_LAST ? PW_LAST : (guard_q != 8'd0 ? guard_q - 8'd1 : 8'd0);
    step_count_d = step_count_q + {15'd0, step_clk_d && !step_clk_q};
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      div_q <= '0;
      pulse_q <= '0;
      guard_q <= '0;
      step_clk_q <= 1'b0;
      btn_level_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync1_q <= button;
      sync2_q <= sync1_q;
      div_q <= div_d;
      pulse_q <= pulse_d;
      guard_q <= guard_d;
      step_clk_q <= step_clk_d;
      btn_level_q <= btn_level_d;
      step_count_q <= step_count_d;
    end
  end
  assign step_clk = step_clk_q;
  assign btn_level = btn_level_q;
  assign step_count = step_count_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed checks of debounce, pulse shaping, auto mode, wrap and reset.
module tb_step_pulse_gen;
  logic CLK, Reset, button, auto_en, step_clk, btn_level;
  logic [15:0] step_count;
  int compared = 0;
  int mismatched = 0;
  step_pulse_gen #(.DEBOUNCE_CYCLES(8), .PULSE_CYCLES(2), .AUTO_PERIOD(10)) dut (
    .CLK(CLK), .Reset(Reset), .button(button), .auto_en(auto_en),
    .step_clk(step_clk), .btn_level(btn_level), .step_count(step_count)
  );
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    Reset = 1'b0;
    button = 1'b0;
    auto_en = 1'b0;
    edges(2);
    Reset = 1'b1;
  endtask
  initial begin
    Reset = 1'b0;
    button = 1'b0;
    auto_en = 1'b0;
    #3;
    chk("rst_step_clk", step_clk, 0);
    chk("rst_btn_level", btn_level, 0);
    chk("rst_step_count", step_count, 0);
    edges(2);
    Reset = 1'b1;
    // clean press: first sample at edge 0, pulse high at edges 10-11
    button = 1'b1;
    edges(10);
    chk("press_e9_step", step_clk, 0);
    chk("press_e9_level", btn_level, 0);
    edges(1);
    chk("press_e10_step", step_clk, 1);
    chk("press_e10_level", btn_level, 1);
    chk("press_e10_count", step_count, 1);
    edges(1);
    chk("press_e11_step", step_clk, 1);
    edges(1);
    chk("press_e12_step", step_clk, 0);
    // release glitch: 4 low cycles while held
    edges(5);
    button = 1'b0;
    edges(4);
    button = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("glitch_level", btn_level, 1);
      chk("glitch_step", step_clk, 0);
      edges(1);
    end
    chk("glitch_count", step_count, 1);
    // debounced release: IDLE reached at edge 10 after first low sample
    button = 1'b0;
    edges(10);
    chk("release_e9_level", btn_level, 1);
    edges(1);
    chk("release_e10_level", btn_level, 0);
    // bounce: toggle every 3 cycles for 30 cycles, then hold
    do_reset();
    for (int c = 0; c < 30; c++) begin
      button = ((c / 3) % 2) == 0;
      edges(1);
      chk("bounce_step", step_clk, 0);
    end
    button = 1'b1;
    for (int j = 0; j < 10; j++) begin
      edges(1);
      chk("bounce_wait_step", step_clk, 0);
    end
    edges(1);
    chk("bounce_rise", step_clk, 1);
    chk("bounce_count", step_count, 1);
    edges(20);
    chk("bounce_single", step_count, 1);
    chk("bounce_level", btn_level, 1);
    // auto mode: rises at edges 9,19,..,99; manual press mid-run ignored
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 43) button = 1'b1;
      edges(1);
      chk("auto_step", step_clk, (i >= 9 && (i - 9) % 10 < 2) ? 1 : 0);
    end
    auto_en = 1'b0;
    edges(1);
    chk("auto_no_truncate", step_clk, 1);
    edges(1);
    chk("auto_fall", step_clk, 0);
    chk("auto_count", step_count, 10);
    chk("auto_level", btn_level, 1);
    edges(20);
    chk("manual_after_auto", step_count, 10);
    // wrap and reset mid-pulse
    do_reset();
    dut.step_count_q <= 16'hffff;
    #1;
    chk("preload", step_count, 16'hffff);
    button = 1'b1;
    edges(11);
    chk("wrap_step", step_clk, 1);
    chk("wrap_count", step_count, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_step", step_clk, 0);
    chk("async_level", btn_level, 0);
    chk("async_count", step_count, 0);
    edges(2);
    Reset = 1'b1;
    for (int j = 0; j < 11; j++) begin
      edges(1);
      chk("post_reset_step", step_clk, j == 10 ? 1 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
